x_stage: RTL and testbench

Execute stage of the in-order pipeline. Consumes the decode-to-execute register outputs and computes ALU results, load/store addresses, branch and jump decisions. Runs an iterative 32-cycle multiplier that stalls upstream stages. Registers everything into the execute-to-memory outputs (m_*) and the fetch redirect outputs.

---
 rtl/x_stage.sv | 188 ++++++++++++++++++
 tb/tb_x_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x_stage.sv
// Execute stage: single-cycle ALU, address and branch evaluation, and an
// iterative shift-add multiplier that stalls upstream while it runs.
module x_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  x_opcode,
    input  logic [5:0]  x_dst_reg,
    input  logic [14:0] x_mem_offset,
    input  logic [14:0] x_brn_offset,
    input  logic [19:0] x_jmp_offset,
    input  logic [31:0] x_read_data_1,
    input  logic [31:0] x_read_data_2,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_offset,
    output logic        m_valid,
    output logic [6:0]  m_opcode,
    output logic [5:0]  m_dst_reg,
    output logic [31:0] m_alu_result,
    output logic [31:0] m_store_data
);

    localparam int MUL_CYCLES = 32;
    localparam logic [4:0] LAST_COUNT = 5'(MUL_CYCLES - 1);

    localparam logic [6:0] OP_ADD = 7'h01;
    localparam logic [6:0] OP_SUB = 7'h02;
    localparam logic [6:0] OP_MUL = 7'h03;
    localparam logic [6:0] OP_LDB = 7'h10;
    localparam logic [6:0] OP_LDW = 7'h11;
    localparam logic [6:0] OP_STB = 7'h12;
    localparam logic [6:0] OP_STW = 7'h13;
    localparam logic [6:0] OP_BEQ = 7'h30;
    localparam logic [6:0] OP_JMP = 7'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;

    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_offset_q, redirect_offset_d;
    logic        m_valid_q, m_valid_d;
    logic [6:0]  m_opcode_q, m_opcode_d;
    logic [5:0]  m_dst_reg_q, m_dst_reg_d;
    logic [31:0] m_alu_result_q, m_alu_result_d;
    logic [31:0] m_store_data_q, m_store_data_d;

    logic [31:0] memAddr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (x_opcode == OP_MUL) begin
                    mcand_d  = x_read_data_1;
                    mplier_d = x_read_data_2;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset overrides stall so upstream is never frozen by a multiply being aborted.
    always_comb begin
        stall = !reset && ((state_q == IDLE && x_opcode == OP_MUL) || state_q == BUSY);
    end

    assign memAddr = x_read_data_1 + {{17{x_mem_offset[14]}}, x_mem_offset};

    always_comb begin
        redirect_valid_d  = 1'b0;
        redirect_offset_d = '0;
        m_valid_d         = 1'b0;
        m_opcode_d        = '0;
        m_dst_reg_d       = '0;
        m_alu_result_d    = '0;
        m_store_data_d    = '0;
        if (!stall) begin
            case (x_opcode)
                OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW: begin
                    m_valid_d   = 1'b1;
                    m_opcode_d  = x_opcode;
                    m_dst_reg_d = x_dst_reg;
                    if (x_opcode == OP_ADD) begin
                        m_alu_result_d = x_read_data_1 + x_read_data_2;
                    end else if (x_opcode == OP_SUB) begin
                        m_alu_result_d = x_read_data_1 - x_read_data_2;
                    end else if (x_opcode == OP_MUL) begin
                        m_alu_result_d = acc_q;
                    end else begin
                        m_alu_result_d = memAddr;
                    end
                end
                OP_STB, OP_STW: begin
                    m_valid_d      = 1'b1;
                    m_opcode_d     = x_opcode;
                    m_alu_result_d = memAddr;
                    m_store_data_d = x_read_data_2;
                end
                OP_BEQ: begin
                    m_valid_d         = 1'b1;
                    m_opcode_d        = x_opcode;
                    redirect_valid_d  = (x_read_data_1 == x_read_data_2);
                    redirect_offset_d = {{17{x_brn_offset[14]}}, x_brn_offset};
                end
                OP_JMP: begin
                    m_valid_d         = 1'b1;
                    m_opcode_d        = x_opcode;
                    redirect_valid_d  = 1'b1;
                    redirect_offset_d = {{12{x_jmp_offset[19]}}, x_jmp_offset};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_valid_q  <= 1'b0;
            redirect_offset_q <= '0;
            m_valid_q         <= 1'b0;
            m_opcode_q        <= '0;
            m_dst_reg_q       <= '0;
            m_alu_result_q    <= '0;
            m_store_data_q    <= '0;
        end else begin
            redirect_valid_q  <= redirect_valid_d;
            redirect_offset_q <= redirect_offset_d;
            m_valid_q         <= m_valid_d;
            m_opcode_q        <= m_opcode_d;
            m_dst_reg_q       <= m_dst_reg_d;
            m_alu_result_q    <= m_alu_result_d;
            m_store_data_q    <= m_store_data_d;
        end
    end

    assign redirect_valid  = redirect_valid_q;
    assign redirect_offset = redirect_offset_q;
    assign m_valid         = m_valid_q;
    assign m_opcode        = m_opcode_q;
    assign m_dst_reg       = m_dst_reg_q;
    assign m_alu_result    = m_alu_result_q;
    assign m_store_data    = m_store_data_q;

endmodule

// File: tb/tb_x_stage.sv
// Bench for x_stage: directed cases with literal expectations, then random
// instruction streams checked against an instruction-level reference model.
module tb_x_stage;

    logic        clock;
    logic        reset;
    logic [6:0]  x_opcode;
    logic [5:0]  x_dst_reg;
    logic [14:0] x_mem_offset;
    logic [14:0] x_brn_offset;
    logic [19:0] x_jmp_offset;
    logic [31:0] x_read_data_1;
    logic [31:0] x_read_data_2;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_offset;
    logic        m_valid;
    logic [6:0]  m_opcode;
    logic [5:0]  m_dst_reg;
    logic [31:0] m_alu_result;
    logic [31:0] m_store_data;

    x_stage dut (
        .clock(clock),
        .reset(reset),
        .x_opcode(x_opcode),
        .x_dst_reg(x_dst_reg),
        .x_mem_offset(x_mem_offset),
        .x_brn_offset(x_brn_offset),
        .x_jmp_offset(x_jmp_offset),
        .x_read_data_1(x_read_data_1),
        .x_read_data_2(x_read_data_2),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_offset(redirect_offset),
        .m_valid(m_valid),
        .m_opcode(m_opcode),
        .m_dst_reg(m_dst_reg),
        .m_alu_result(m_alu_result),
        .m_store_data(m_store_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    // Model state: how many edges the current MUL has spent in execute.
    int          mulAge = 0;
    bit          consumed;
    logic        expRv;
    logic [31:0] expRo;
    logic        expValid;
    logic [6:0]  expOp;
    logic [5:0]  expDst;
    logic [31:0] expRes;
    logic [31:0] expStore;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelStall();
        return !reset && x_opcode == 7'h03 && mulAge < 33;
    endfunction

    task automatic modelReset();
        mulAge   = 0;
        expRv    = 0;
        expRo    = 0;
        expValid = 0;
        expOp    = 0;
        expDst   = 0;
        expRes   = 0;
        expStore = 0;
    endtask

    // Called right after each rising edge: what the registered outputs now hold.
    task automatic modelEdge();
        logic [63:0] prod;
        logic signed [31:0] memOff, brnOff, jmpOff;
        consumed = 0;
        if (reset) begin
            modelReset();
            return;
        end
        expRv = 0; expRo = 0; expValid = 0; expOp = 0; expDst = 0; expRes = 0; expStore = 0;
        if (x_opcode == 7'h03 && mulAge < 33) begin
            mulAge++;
            return;
        end
        consumed = 1;
        mulAge   = 0;
        memOff = $signed(x_mem_offset);
        brnOff = $signed(x_brn_offset);
        jmpOff = $signed(x_jmp_offset);
        prod   = 64'(x_read_data_1) * 64'(x_read_data_2);
        case (x_opcode)
            7'h01: begin expValid = 1; expOp = x_opcode; expDst = x_dst_reg; expRes = x_read_data_1 + x_read_data_2; end
            7'h02: begin expValid = 1; expOp = x_opcode; expDst = x_dst_reg; expRes = x_read_data_1 - x_read_data_2; end
            7'h03: begin expValid = 1; expOp = x_opcode; expDst = x_dst_reg; expRes = prod[31:0]; end
            7'h10, 7'h11: begin
                expValid = 1; expOp = x_opcode; expDst = x_dst_reg;
                expRes = x_read_data_1 + memOff;
            end
            7'h12, 7'h13: begin
                expValid = 1; expOp = x_opcode;
                expRes = x_read_data_1 + memOff; expStore = x_read_data_2;
            end
            7'h30: begin expValid = 1; expOp = x_opcode; expRv = (x_read_data_1 == x_read_data_2); expRo = brnOff; end
            7'h40: begin expValid = 1; expOp = x_opcode; expRv = 1; expRo = jmpOff; end
            default: ;
        endcase
    endtask

    task automatic compareAll();
        checkOutput("m_valid", 32'(m_valid), 32'(expValid));
        checkOutput("m_opcode", 32'(m_opcode), 32'(expOp));
        checkOutput("m_dst_reg", 32'(m_dst_reg), 32'(expDst));
        checkOutput("m_alu_result", m_alu_result, expRes);
        checkOutput("m_store_data", m_store_data, expStore);
        checkOutput("redirect_valid", 32'(redirect_valid), 32'(expRv));
        checkOutput("redirect_offset", redirect_offset, expRo);
    endtask

    // One clock: check stall for the current inputs, take the edge, check outputs.
    task automatic stepCycle(output bit wasStalled);
        #1;
        checkOutput("stall", 32'(stall), 32'(modelStall()));
        wasStalled = stall;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        compareAll();
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [5:0] dst,
                                 input logic [14:0] mo, input logic [14:0] bo,
                                 input logic [19:0] jo, input logic [31:0] a,
                                 input logic [31:0] b, output int stallCycles);
        bit st;
        x_opcode = op; x_dst_reg = dst; x_mem_offset = mo; x_brn_offset = bo;
        x_jmp_offset = jo; x_read_data_1 = a; x_read_data_2 = b;
        stallCycles = 0;
        for (int i = 0; i < 100; i++) begin
            stepCycle(st);
            if (st) stallCycles++;
            if (consumed) return;
        end
        checkOutput("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  sc;
        bit  st;
        logic [6:0] ops [0:10];
        ops = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h10, 7'h11, 7'h12, 7'h13, 7'h30, 7'h40, 7'h55};

        reset = 1'b1;
        x_opcode = 7'h03; x_dst_reg = 0; x_mem_offset = 0; x_brn_offset = 0;
        x_jmp_offset = 0; x_read_data_1 = 0; x_read_data_2 = 0;
        modelReset();
        @(negedge clock);
        @(negedge clock);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        compareAll();
        x_opcode = 7'h00;
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(7'h01, 6'd5, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, sc);
        checkOutput("add_valid", 32'(m_valid), 32'd1);
        checkOutput("add_opcode", 32'(m_opcode), 32'h01);
        checkOutput("add_wrap", m_alu_result, 32'h0);
        checkOutput("add_rv", 32'(redirect_valid), 32'd0);

        applyStimulus(7'h11, 6'd9, 15'h7FFC, 0, 0, 32'h100, 32'd0, sc);
        checkOutput("ldw_addr", m_alu_result, 32'hFC);
        checkOutput("ldw_dst", 32'(m_dst_reg), 32'd9);
        applyStimulus(7'h13, 6'd7, 15'h7FFC, 0, 0, 32'h100, 32'hDEAD_BEEF, sc);
        checkOutput("stw_data", m_store_data, 32'hDEAD_BEEF);
        checkOutput("stw_dst", 32'(m_dst_reg), 32'd0);

        applyStimulus(7'h30, 6'd3, 0, 15'h4000, 0, 32'd5, 32'd5, sc);
        checkOutput("beq_taken", 32'(redirect_valid), 32'd1);
        checkOutput("beq_offset", redirect_offset, 32'hFFFF_C000);
        applyStimulus(7'h30, 6'd3, 0, 15'h4000, 0, 32'd5, 32'd6, sc);
        checkOutput("beq_not_taken", 32'(redirect_valid), 32'd0);
        checkOutput("beq_valid", 32'(m_valid), 32'd1);
        applyStimulus(7'h40, 6'd0, 0, 0, 20'h80000, 32'd0, 32'd0, sc);
        checkOutput("jmp_offset", redirect_offset, 32'hFFF8_0000);

        applyStimulus(7'h03, 6'd12, 0, 0, 0, 32'h0001_0001, 32'h0000_FFFF, sc);
        checkOutput("mul_stall_cycles", 32'(sc), 32'd33);
        checkOutput("mul_result", m_alu_result, 32'hFFFF_FFFF);
        checkOutput("mul_valid", 32'(m_valid), 32'd1);
        applyStimulus(7'h01, 6'd1, 0, 0, 0, 32'd2, 32'd3, sc);
        checkOutput("add_after_mul_stall", 32'(sc), 32'd0);
        checkOutput("add_after_mul", m_alu_result, 32'd5);
        applyStimulus(7'h03, 6'd2, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc);
        checkOutput("mul_ff_result", m_alu_result, 32'h1);

        // Abort a multiply partway through BUSY with an asynchronous reset.
        x_opcode = 7'h03; x_dst_reg = 6'd4; x_read_data_1 = 32'd7; x_read_data_2 = 32'd9;
        for (int i = 0; i < 11; i++) stepCycle(st);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_valid", 32'(m_valid), 32'd0);
        compareAll();
        x_opcode = 7'h00;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle(st);
        checkOutput("abort_no_result", 32'(m_valid), 32'd0);
        applyStimulus(7'h03, 6'd6, 0, 0, 0, 32'd1234, 32'd5678, sc);
        checkOutput("mul_after_abort_stall", 32'(sc), 32'd33);
        checkOutput("mul_after_abort", m_alu_result, 32'd7006652);

        for (int n = 0; n < 250; n++) begin
            logic [6:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 10)];
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
            applyStimulus(op, 6'($urandom), 15'($urandom), 15'($urandom),
                          20'($urandom), a, b, sc);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
